// File: rtl/frog_vga_pkg.sv
// frog_vga_pkg -- shared types and constants for the frog scene VGA engine.
//   frog_state_t : frog jump / death state machine encoding
//   *_RGB        : 12-bit {r,g,b} colour constants
//   VGA_*        : default 640x480@60 timing and scene geometry
//   COORD_W      : width of all pixel coordinates (11-bit, signed where needed)
// Optional build macro used by the top: WATER_GRADIENT_EN.
package frog_vga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UP_OUT,
    ST_UP_BACK,
    ST_DN_OUT,
    ST_DN_BACK,
    ST_DEAD
  } frog_state_t;

  localparam int COORD_W = 11;

  localparam logic [11:0] FROG_RGB   = 12'hFFF;
  localparam logic [11:0] PAD_RGB    = 12'h0F0;
  localparam logic [11:0] WATER_FLAT = 12'h008;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- horizontal/vertical pixel counters and sync generation.
//   clk, rst_n  : pixel clock, synchronous active-low reset
//   h, v        : current pixel counters (combinational view of the raster)
//   active      : h/v inside the visible area
//   frame_end   : counters at the last pixel of the frame (internal event)
//   hsync/vsync : active-low sync, registered (one clock behind h/v)
//   frame_tick  : frame_end registered, aligned with sync and colour
module vga_timing_gen
  import frog_vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] h,
  output logic [COORD_W-1:0] v,
  output logic               active,
  output logic               frame_end,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  assign active    = (h < H_ACT) && (v < V_ACT);
  assign frame_end = (h == H_LAST) && (v == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h          <= '0;
      v          <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= !((h >= HS_BEG) && (h < HS_END));
      vsync      <= !((v >= VS_BEG) && (v < VS_END));
      frame_tick <= frame_end;
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + ONE;
      end else begin
        h <= h + ONE;
      end
    end
  end

endmodule

// File: rtl/frog_scene_vga.sv
// frog_scene_vga -- VGA scene: scrolling lily pads, jumping frog, collision, death blink.
//   clk, rst_n           : pixel clock, synchronous active-low reset
//   jump_up/jump_down    : single-cycle jump requests, honoured only while IDLE
//   restart              : single-cycle request, clears death and rewinds the pads
//   hsync, vsync         : active-low sync (registered)
//   vga_r, vga_g, vga_b  : 4-bit colour, zero outside the visible area (registered)
//   frame_tick           : pulse aligned with the last pixel of the frame
//   pad_hit              : per-pad collision flags of the previous frame
//   dead                 : frog state machine is in DEAD
// Build macro WATER_GRADIENT_EN: water blue darkens by one step every 16 lines.
//
// Frog states (all moves on the frame_end event, restart acts immediately):
//   state      | meaning
//   ST_IDLE    | frog at rest, jump requests latched as pending
//   ST_UP_OUT  | rising 2 px/frame until JUMP_H above rest
//   ST_UP_BACK | falling back 2 px/frame to rest
//   ST_DN_OUT  | sinking 2 px/frame until JUMP_H below rest
//   ST_DN_BACK | rising back 2 px/frame to rest
//   ST_DEAD    | frog and pads frozen, frog blinks until restart
module frog_scene_vga
  import frog_vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter int NUM_PADS   = 3,
  parameter int PAD_W      = 40,
  parameter int PAD_PITCH  = 240,
  parameter int PAD_TOP    = 190,
  parameter int PAD_BOT    = 286,
  parameter int PAD_SPEED  = 3,
  parameter int FROG_X     = 120,
  parameter int FROG_Y     = 232,
  parameter int FROG_SZ    = 16,
  parameter int JUMP_H     = 32,
  parameter int BLINK_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                jump_up,
  input  logic                jump_down,
  input  logic                restart,
  output logic                hsync,
  output logic                vsync,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                frame_tick,
  output logic [NUM_PADS-1:0] pad_hit,
  output logic                dead
);

  localparam int CW = COORD_W;

  localparam logic [CW-1:0] TWO     = CW'(2);
  localparam logic [CW-1:0] PITCH_C = CW'(PAD_PITCH);
  localparam logic [CW-1:0] SPEED_C = CW'(PAD_SPEED);
  localparam logic [CW-1:0] PT_C    = CW'(PAD_TOP);
  localparam logic [CW-1:0] PB_C    = CW'(PAD_BOT);
  localparam logic [CW-1:0] FX_C    = CW'(FROG_X);
  localparam logic [CW-1:0] FX_END  = CW'(FROG_X + FROG_SZ);
  localparam logic [CW-1:0] SZ_C    = CW'(FROG_SZ);
  localparam logic [CW-1:0] Y_REST  = CW'(FROG_Y);
  localparam logic [CW-1:0] Y_TOP   = CW'(FROG_Y - JUMP_H);
  localparam logic [CW-1:0] Y_BOT   = CW'(FROG_Y + JUMP_H);
  localparam logic [CW-1:0] V_HALF  = CW'(V_ACTIVE / 2);
  localparam logic signed [CW-1:0] PW_S = CW'(PAD_W);
  localparam int BL_W = BLINK_LOG2 + 1;

  logic [CW-1:0] h, v;
  logic          active, frame_end;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .h         (h),
    .v         (v),
    .active    (active),
    .frame_end (frame_end),
    .hsync     (hsync),
    .vsync     (vsync),
    .frame_tick(frame_tick)
  );

  frog_state_t         state, state_n;
  logic [CW-1:0]       frog_y, frog_y_n, y_minus, y_plus;
  logic [CW-1:0]       scroll, scroll_n, scroll_sum, scroll_adv;
  logic [BLINK_LOG2:0] blink, blink_n;
  logic [NUM_PADS-1:0] hit, in_pad;
  logic                pend_up, pend_dn;
  logic                pad_band, in_frog, frog_vis;
  logic [3:0]          water_b;
  logic [11:0]         pix, rgb;

  assign scroll_sum = scroll + SPEED_C;
  assign scroll_adv = (scroll_sum >= PITCH_C) ? scroll_sum - PITCH_C : scroll_sum;
  assign y_minus    = frog_y - TWO;
  assign y_plus     = frog_y + TWO;

  // Pad edges are signed so a pad scrolled partly past x=0 clips instead of wrapping.
  assign pad_band = (v >= PT_C) && (v < PB_C);

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    localparam logic signed [CW-1:0] BASE = CW'(i * PAD_PITCH + PAD_W / 2);
    logic signed [CW-1:0] left;
    assign left      = BASE - $signed(scroll);
    assign in_pad[i] = pad_band && ($signed(h) >= left) && ($signed(h) < left + PW_S);
  end

  // Collision uses the frog's box even while it is blinked out.
  assign in_frog  = (h >= FX_C) && (h < FX_END) && (v >= frog_y) && (v < frog_y + SZ_C);
  assign frog_vis = in_frog && ((state != ST_DEAD) || !blink[BLINK_LOG2]);
  assign dead     = (state == ST_DEAD);

`ifdef WATER_GRADIENT_EN
  assign water_b = 4'hF - 4'((v - V_HALF) >> 4);
`else
  assign water_b = WATER_FLAT[3:0];
`endif

  always_comb begin
    pix = 12'h000;
    if (active) begin
      if (frog_vis)          pix = FROG_RGB;
      else if (|in_pad)      pix = PAD_RGB;
      else if (v >= V_HALF)  pix = {8'h00, water_b};
    end
  end

  always_comb begin
    state_n  = state;
    frog_y_n = frog_y;
    blink_n  = blink;
    scroll_n = scroll;
    if (restart) begin
      state_n  = ST_IDLE;
      frog_y_n = Y_REST;
      scroll_n = '0;
    end else if (frame_end) begin
      if (state != ST_DEAD) scroll_n = scroll_adv;
      if ((state != ST_DEAD) && (|hit)) begin
        state_n = ST_DEAD;
        blink_n = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (pend_up)      state_n = ST_UP_OUT;
            else if (pend_dn) state_n = ST_DN_OUT;
          end
          ST_UP_OUT: begin
            frog_y_n = y_minus;
            if (y_minus == Y_TOP) state_n = ST_UP_BACK;
          end
          ST_UP_BACK: begin
            frog_y_n = y_plus;
            if (y_plus == Y_REST) state_n = ST_IDLE;
          end
          ST_DN_OUT: begin
            frog_y_n = y_plus;
            if (y_plus == Y_BOT) state_n = ST_DN_BACK;
          end
          ST_DN_BACK: begin
            frog_y_n = y_minus;
            if (y_minus == Y_REST) state_n = ST_IDLE;
          end
          ST_DEAD:  blink_n = blink + BL_W'(1);
          default:  state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      frog_y  <= Y_REST;
      blink   <= '0;
      scroll  <= '0;
      hit     <= '0;
      pad_hit <= '0;
      pend_up <= 1'b0;
      pend_dn <= 1'b0;
      rgb     <= 12'h000;
    end else begin
      state  <= state_n;
      frog_y <= frog_y_n;
      blink  <= blink_n;
      scroll <= scroll_n;
      rgb    <= pix;
      if (restart) begin
        hit     <= '0;
        pend_up <= 1'b0;
        pend_dn <= 1'b0;
      end else if (frame_end) begin
        pad_hit <= hit;
        hit     <= '0;
        pend_up <= 1'b0;
        pend_dn <= 1'b0;
      end else begin
        hit <= hit | ((active && in_frog) ? in_pad : '0);
        // Up wins over a simultaneous down; once out of IDLE requests are dropped.
        if (state == ST_IDLE) begin
          if (jump_up)        pend_up <= 1'b1;
          else if (jump_down) pend_dn <= 1'b1;
        end else begin
          pend_up <= 1'b0;
          pend_dn <= 1'b0;
        end
      end
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_frog_scene_vga.sv
// tb_frog_scene_vga -- bench for frog_scene_vga on a shrunken raster (32x20 clocks per frame)
// so many frames fit in a short run. A frame-level reference model tracks scroll, frog
// position, jump/death state and blink; collisions are predicted by rectangle overlap.
module tb_frog_scene_vga;

  localparam int HA = 24, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 16, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int NP = 3, PW = 4, PP = 12, PT = 6, PB = 13, PS = 1;
  localparam int FX = 8, FY = 7, FS = 2, JH = 4, BL = 1;
  localparam int FRAME = HT * VT;

  localparam int M_IDLE = 0, M_UP_OUT = 1, M_UP_BACK = 2, M_DN_OUT = 3, M_DN_BACK = 4, M_DEAD = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          jump_up = 1'b0, jump_down = 1'b0, restart = 1'b0;
  logic          hsync, vsync, frame_tick, dead;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic [NP-1:0] pad_hit;

  frog_scene_vga #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .NUM_PADS(NP), .PAD_W(PW), .PAD_PITCH(PP), .PAD_TOP(PT), .PAD_BOT(PB),
    .PAD_SPEED(PS), .FROG_X(FX), .FROG_Y(FY), .FROG_SZ(FS), .JUMP_H(JH),
    .BLINK_LOG2(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .jump_up(jump_up), .jump_down(jump_down),
    .restart(restart), .hsync(hsync), .vsync(vsync), .vga_r(vga_r),
    .vga_g(vga_g), .vga_b(vga_b), .frame_tick(frame_tick), .pad_hit(pad_hit),
    .dead(dead)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_state, m_y, m_scroll, m_blink, m_h, m_v;
  bit m_pu, m_pd;
  logic [NP-1:0] m_pad_hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] water_blue(int v);
`ifdef WATER_GRADIENT_EN
    return 4'hF - 4'((v - VA / 2) / 16);
`else
    return 4'h8;
`endif
  endfunction

  function automatic logic [11:0] exp_pixel(int h, int v);
    int lx;
    bit vis;
    if (h >= HA || v >= VA) return 12'h000;
    vis = (h >= FX) && (h < FX + FS) && (v >= m_y) && (v < m_y + FS);
    if (m_state == M_DEAD && ((m_blink >> BL) & 1) == 1) vis = 0;
    if (vis) return 12'hFFF;
    for (int i = 0; i < NP; i++) begin
      lx = i * PP - m_scroll + PW / 2;
      if (h >= lx && h < lx + PW && v >= PT && v < PB) return 12'h0F0;
    end
    if (v >= VA / 2) return {8'h00, water_blue(v)};
    return 12'h000;
  endfunction

  // Per-pad overlap of the frog and pad rectangles, both clipped to the visible area.
  function automatic logic [NP-1:0] frame_hits();
    logic [NP-1:0] r;
    int lx, xo, yo;
    r = '0;
    yo = imin(imin(PB, m_y + FS), VA) - imax(imax(PT, m_y), 0);
    for (int i = 0; i < NP; i++) begin
      lx = i * PP - m_scroll + PW / 2;
      xo = imin(imin(lx + PW, FX + FS), HA) - imax(imax(lx, FX), 0);
      r[i] = (xo > 0) && (yo > 0);
    end
    return r;
  endfunction

  task automatic frame_update();
    logic [NP-1:0] hits;
    bit was_dead;
    hits = frame_hits();
    m_pad_hit = hits;
    was_dead = (m_state == M_DEAD);
    if (!was_dead) m_scroll = (m_scroll + PS) % PP;
    if (!was_dead && hits != 0) begin
      m_state = M_DEAD;
      m_blink = 0;
    end else begin
      case (m_state)
        M_IDLE:    if (m_pu) m_state = M_UP_OUT; else if (m_pd) m_state = M_DN_OUT;
        M_UP_OUT:  begin m_y -= 2; if (m_y == FY - JH) m_state = M_UP_BACK; end
        M_UP_BACK: begin m_y += 2; if (m_y == FY) m_state = M_IDLE; end
        M_DN_OUT:  begin m_y += 2; if (m_y == FY + JH) m_state = M_DN_BACK; end
        M_DN_BACK: begin m_y -= 2; if (m_y == FY) m_state = M_IDLE; end
        default:   m_blink++;
      endcase
    end
    m_pu = 0;
    m_pd = 0;
  endtask

  // One pixel clock: drive inputs, predict, clock, compare.
  task automatic cycle(input bit ju, input bit jd, input bit rs);
    logic [11:0] e_rgb;
    bit e_hs, e_vs, last;
    jump_up = ju;
    jump_down = jd;
    restart = rs;
    e_rgb = exp_pixel(m_h, m_v);
    e_hs = !(m_h >= HA + HF && m_h < HA + HF + HS);
    e_vs = !(m_v >= VA + VF && m_v < VA + VF + VS);
    last = (m_h == HT - 1) && (m_v == VT - 1);
    if (rs) begin
      m_state = M_IDLE; m_y = FY; m_scroll = 0; m_pu = 0; m_pd = 0;
    end else if (last) begin
      frame_update();
    end else if (m_state == M_IDLE) begin
      if (ju) m_pu = 1; else if (jd) m_pd = 1;
    end
    if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
    @(posedge clk);
    #1;
    chk("rgb", {vga_r, vga_g, vga_b}, e_rgb);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("frame_tick", frame_tick, last);
    chk("dead", dead, m_state == M_DEAD);
    chk("pad_hit", pad_hit, m_pad_hit);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    jump_up = 1'b0; jump_down = 1'b0; restart = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk("rst_hsync", hsync, 1'b1);
      chk("rst_vsync", vsync, 1'b1);
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
      chk("rst_tick", frame_tick, 1'b0);
      chk("rst_pad_hit", pad_hit, '0);
      chk("rst_dead", dead, 1'b0);
    end
    rst_n = 1'b1;
    m_h = 0; m_v = 0; m_state = M_IDLE; m_y = FY; m_scroll = 0; m_blink = 0;
    m_pu = 0; m_pd = 0; m_pad_hit = '0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0);
  endtask

  task automatic to_pixel(input int h, input int v);
    for (int k = 0; k < FRAME && !(m_h == h && m_v == v); k++) cycle(0, 0, 0);
  endtask

  initial begin
    bit ju, jd, rs;
    int tick_gap;

    do_reset(3);
    run(FRAME);

    // Jump up from IDLE, then a down request mid-jump that must be ignored.
    to_pixel(5, 3);
    cycle(1, 0, 0);
    to_pixel(0, 0);
    to_pixel(10, 2);
    cycle(0, 1, 0);
    run(4 * FRAME);

    // Pads reach the frog; stay dead long enough to see several blink phases.
    run(8 * FRAME);
    chk("dead_after_collision", dead, 1'b1);

    // Restart with a simultaneous jump: restart wins, no jump starts.
    to_pixel(3, 5);
    cycle(1, 0, 1);
    chk("restart_clears_dead", dead, 1'b0);
    run(2 * FRAME);

    // Both requests in one cycle: up wins.
    to_pixel(2, 2);
    cycle(1, 1, 0);
    run(3 * FRAME);

    // Mid-frame reset: first frame_tick must come a full frame later.
    to_pixel(7, 9);
    do_reset(2);
    tick_gap = 0;
    for (int k = 0; k < FRAME + 4 && !frame_tick; k++) begin
      cycle(0, 0, 0);
      tick_gap++;
    end
    chk("first_tick_gap", tick_gap, FRAME);
    run(FRAME);

    // Random requests and restarts.
    for (int k = 0; k < 40 * FRAME; k++) begin
      ju = ($urandom_range(0, 499) == 0);
      jd = ($urandom_range(0, 499) == 0);
      rs = ($urandom_range(0, (m_state == M_DEAD) ? 1999 : 29999) == 0);
      cycle(ju, jd, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
